reservation_station: RTL and testbench

// - Receiving end of the dispatcher->RS issue interface: buffers non-memory ops (ALU, branch, jump, LUI/AUIPC).
// - Snoops the Arith and LS CDBs to resolve pending operands; issues one ready op per cycle to the arithmetic unit.
// - Raises full back to the fetcher so the dispatcher never overruns it. Sits between dispatcher and Arith unit.

---
 rtl/reservation_station_pkg.sv | 32 +++
 rtl/reservation_station_priority_encoder.sv | 23 ++
 rtl/reservation_station.sv | 167 ++++++++++++++++
 tb/tb_reservation_station.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reservation_station_pkg.sv
// Shared types and constants for the reservation station and its helpers.
package reservation_station_pkg;

  localparam int ROB_ID_W = 5;
  localparam int OPENUM_W = 6;
  localparam int WORD_W   = 32;

  typedef logic [ROB_ID_W-1:0] rob_id_t;
  typedef logic [OPENUM_W-1:0] openum_t;
  typedef logic [WORD_W-1:0]   word_t;

  localparam rob_id_t ZERO_ROB   = '0;
  localparam openum_t OPENUM_NOP = '0;
  localparam word_t   ZERO_WORD  = '0;

  typedef struct packed {
    openum_t openum;
    word_t   v1;
    word_t   v2;
    rob_id_t q1;
    rob_id_t q2;
    word_t   pc;
    word_t   imm;
    rob_id_t rob_id;
  } rs_entry_t;

  // A CDB broadcast resolves an operand only when valid and the tag is a real (non-zero) producer.
  function automatic logic cdb_hit(input logic valid, input rob_id_t cdb_tag, input rob_id_t q);
    return valid && (q != ZERO_ROB) && (q == cdb_tag);
  endfunction

endpackage

// File: rtl/reservation_station_priority_encoder.sv
// Lowest-index-first priority encoder over a request vector.
module rs_priority_encoder #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         found
);

  // Scan from the top down so the lowest set bit is the final winner.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Reservation station for non-memory ops: buffers dispatched ops, snoops both
// CDBs for operand wakeup and issues one ready op per cycle to the Arith unit.
import reservation_station_pkg::*;

module reservation_station #(
  parameter int RS_SIZE  = 16,
  parameter int RS_IDX_W = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    rdy,
  input  logic    rollback,
  input  logic    ena_from_disp,
  input  openum_t openum_from_disp,
  input  word_t   V1_from_disp,
  input  word_t   V2_from_disp,
  input  rob_id_t Q1_from_disp,
  input  rob_id_t Q2_from_disp,
  input  word_t   pc_from_disp,
  input  word_t   imm_from_disp,
  input  rob_id_t rob_id_from_disp,
  output logic    full_to_if,
  input  logic    arith_cdb_valid,
  input  rob_id_t arith_cdb_rob_id,
  input  word_t   arith_cdb_result,
  input  logic    ls_cdb_valid,
  input  rob_id_t ls_cdb_rob_id,
  input  word_t   ls_cdb_result,
  output logic    ena_to_alu,
  output openum_t openum_to_alu,
  output word_t   V1_to_alu,
  output word_t   V2_to_alu,
  output word_t   pc_to_alu,
  output word_t   imm_to_alu,
  output rob_id_t rob_id_to_alu
);

  localparam int CNT_W = RS_IDX_W + 1;

  logic [RS_SIZE-1:0]  busy;
  rs_entry_t           entry [RS_SIZE];
  logic [CNT_W-1:0]    busy_count;
  logic [RS_SIZE-1:0]  ready_vec;
  logic [RS_IDX_W-1:0] free_idx;
  logic [RS_IDX_W-1:0] ready_idx;
  logic                free_found;
  logic                ready_found;
  logic                do_insert;
  logic                do_issue;
  rs_entry_t           incoming;

  // Two slots of slack absorb the dispatcher register and the fetch already in flight.
  assign full_to_if = busy_count >= CNT_W'(RS_SIZE - 2);
  assign do_insert  = ena_from_disp && free_found;
  assign do_issue   = ready_found;

  // An entry is ready once both producer tags have been resolved.
  always_comb begin
    ready_vec = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      ready_vec[i] = busy[i] && (entry[i].q1 == ZERO_ROB) && (entry[i].q2 == ZERO_ROB);
    end
  end

  rs_priority_encoder #(.N(RS_SIZE), .W(RS_IDX_W)) u_free_sel (
    .req   (~busy),
    .idx   (free_idx),
    .found (free_found)
  );

  rs_priority_encoder #(.N(RS_SIZE), .W(RS_IDX_W)) u_ready_sel (
    .req   (ready_vec),
    .idx   (ready_idx),
    .found (ready_found)
  );

  // Build the entry to insert, forwarding a CDB result that lands in the dispatch cycle.
  always_comb begin
    incoming.openum = openum_from_disp;
    incoming.pc     = pc_from_disp;
    incoming.imm    = imm_from_disp;
    incoming.rob_id = rob_id_from_disp;
    incoming.v1     = V1_from_disp;
    incoming.q1     = Q1_from_disp;
    incoming.v2     = V2_from_disp;
    incoming.q2     = Q2_from_disp;
    if (cdb_hit(arith_cdb_valid, arith_cdb_rob_id, Q1_from_disp)) begin
      incoming.v1 = arith_cdb_result;
      incoming.q1 = ZERO_ROB;
    end else if (cdb_hit(ls_cdb_valid, ls_cdb_rob_id, Q1_from_disp)) begin
      incoming.v1 = ls_cdb_result;
      incoming.q1 = ZERO_ROB;
    end
    if (cdb_hit(arith_cdb_valid, arith_cdb_rob_id, Q2_from_disp)) begin
      incoming.v2 = arith_cdb_result;
      incoming.q2 = ZERO_ROB;
    end else if (cdb_hit(ls_cdb_valid, ls_cdb_rob_id, Q2_from_disp)) begin
      incoming.v2 = ls_cdb_result;
      incoming.q2 = ZERO_ROB;
    end
  end

  // Occupancy, occupancy count and the issue port registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy          <= '0;
      busy_count    <= '0;
      ena_to_alu    <= 1'b0;
      openum_to_alu <= OPENUM_NOP;
      V1_to_alu     <= ZERO_WORD;
      V2_to_alu     <= ZERO_WORD;
      pc_to_alu     <= ZERO_WORD;
      imm_to_alu    <= ZERO_WORD;
      rob_id_to_alu <= ZERO_ROB;
    end else if (rdy) begin
      if (rollback) begin
        busy       <= '0;
        busy_count <= '0;
        ena_to_alu <= 1'b0;
      end else begin
        ena_to_alu <= do_issue;
        if (do_issue) begin
          busy[ready_idx] <= 1'b0;
          openum_to_alu   <= entry[ready_idx].openum;
          V1_to_alu       <= entry[ready_idx].v1;
          V2_to_alu       <= entry[ready_idx].v2;
          pc_to_alu       <= entry[ready_idx].pc;
          imm_to_alu      <= entry[ready_idx].imm;
          rob_id_to_alu   <= entry[ready_idx].rob_id;
        end
        // The free slot comes from pre-edge busy, so it can never be the issuing slot.
        if (do_insert) begin
          busy[free_idx] <= 1'b1;
        end
        busy_count <= busy_count + CNT_W'(do_insert) - CNT_W'(do_issue);
      end
    end
  end

  // Entry payload: CDB snoop on occupied slots and insertion into the chosen free slot.
  always_ff @(posedge clk) begin
    if (rdy && !rollback) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy[i]) begin
          if (cdb_hit(arith_cdb_valid, arith_cdb_rob_id, entry[i].q1)) begin
            entry[i].v1 <= arith_cdb_result;
            entry[i].q1 <= ZERO_ROB;
          end else if (cdb_hit(ls_cdb_valid, ls_cdb_rob_id, entry[i].q1)) begin
            entry[i].v1 <= ls_cdb_result;
            entry[i].q1 <= ZERO_ROB;
          end
          if (cdb_hit(arith_cdb_valid, arith_cdb_rob_id, entry[i].q2)) begin
            entry[i].v2 <= arith_cdb_result;
            entry[i].q2 <= ZERO_ROB;
          end else if (cdb_hit(ls_cdb_valid, ls_cdb_rob_id, entry[i].q2)) begin
            entry[i].v2 <= ls_cdb_result;
            entry[i].q2 <= ZERO_ROB;
          end
        end
      end
      if (do_insert) begin
        entry[free_idx] <= incoming;
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Testbench for reservation_station: directed scenarios followed by random
// traffic, all checked cycle by cycle against a slot-list reference model.
module tb_reservation_station;
  import reservation_station_pkg::*;

  localparam int N = 16;

  logic    clk = 1'b0;
  logic    rst, rdy, rollback, ena_from_disp;
  openum_t openum_from_disp;
  word_t   V1_from_disp, V2_from_disp, pc_from_disp, imm_from_disp;
  rob_id_t Q1_from_disp, Q2_from_disp, rob_id_from_disp;
  logic    full_to_if;
  logic    arith_cdb_valid, ls_cdb_valid;
  rob_id_t arith_cdb_rob_id, ls_cdb_rob_id;
  word_t   arith_cdb_result, ls_cdb_result;
  logic    ena_to_alu;
  openum_t openum_to_alu;
  word_t   V1_to_alu, V2_to_alu, pc_to_alu, imm_to_alu;
  rob_id_t rob_id_to_alu;

  reservation_station dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .ena_from_disp(ena_from_disp), .openum_from_disp(openum_from_disp),
    .V1_from_disp(V1_from_disp), .V2_from_disp(V2_from_disp),
    .Q1_from_disp(Q1_from_disp), .Q2_from_disp(Q2_from_disp),
    .pc_from_disp(pc_from_disp), .imm_from_disp(imm_from_disp),
    .rob_id_from_disp(rob_id_from_disp), .full_to_if(full_to_if),
    .arith_cdb_valid(arith_cdb_valid), .arith_cdb_rob_id(arith_cdb_rob_id),
    .arith_cdb_result(arith_cdb_result),
    .ls_cdb_valid(ls_cdb_valid), .ls_cdb_rob_id(ls_cdb_rob_id),
    .ls_cdb_result(ls_cdb_result),
    .ena_to_alu(ena_to_alu), .openum_to_alu(openum_to_alu),
    .V1_to_alu(V1_to_alu), .V2_to_alu(V2_to_alu), .pc_to_alu(pc_to_alu),
    .imm_to_alu(imm_to_alu), .rob_id_to_alu(rob_id_to_alu)
  );

  always #5 clk = ~clk;

  // Reference model: a list of slots plus the expected issue-port contents.
  typedef struct {
    logic    busy;
    openum_t op;
    word_t   v1, v2, pc, imm;
    rob_id_t q1, q2, rob;
  } slot_t;

  slot_t   m [N];
  logic    m_ena;
  openum_t m_op;
  word_t   m_v1, m_v2, m_pc, m_imm;
  rob_id_t m_rob;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) if (m[i].busy) c++;
    return c;
  endfunction

  function automatic logic hit(input logic v, input rob_id_t t, input rob_id_t q);
    return v && (q != 0) && (q == t);
  endfunction

  // Resolve one operand against both broadcasts (arith first).
  task automatic resolve(inout word_t v, inout rob_id_t q);
    if (hit(arith_cdb_valid, arith_cdb_rob_id, q)) begin
      v = arith_cdb_result; q = 0;
    end else if (hit(ls_cdb_valid, ls_cdb_rob_id, q)) begin
      v = ls_cdb_result; q = 0;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m[i].busy = 1'b0;
    m_ena = 1'b0; m_op = 0; m_v1 = 0; m_v2 = 0; m_pc = 0; m_imm = 0; m_rob = 0;
  endtask

  // Advance the model by one clock edge using the inputs held during the cycle.
  task automatic model_edge();
    slot_t n [N];
    int r, f;
    n = m;
    if (rst) begin
      model_reset();
      return;
    end
    if (!rdy) return;
    if (rollback) begin
      for (int i = 0; i < N; i++) m[i].busy = 1'b0;
      m_ena = 1'b0;
      return;
    end
    r = -1; f = -1;
    for (int i = 0; i < N; i++) begin
      if (r < 0 && m[i].busy && m[i].q1 == 0 && m[i].q2 == 0) r = i;
      if (f < 0 && !m[i].busy) f = i;
    end
    for (int i = 0; i < N; i++) begin
      if (m[i].busy) begin
        resolve(n[i].v1, n[i].q1);
        resolve(n[i].v2, n[i].q2);
      end
    end
    if (r >= 0) begin
      m_ena = 1'b1;
      m_op = m[r].op; m_v1 = m[r].v1; m_v2 = m[r].v2;
      m_pc = m[r].pc; m_imm = m[r].imm; m_rob = m[r].rob;
      n[r].busy = 1'b0;
    end else begin
      m_ena = 1'b0;
    end
    if (ena_from_disp) begin
      if (f < 0) begin
        chk("disp_overrun", 32'(m_count()), 32'(N - 1));
      end else begin
        n[f].busy = 1'b1; n[f].op = openum_from_disp;
        n[f].v1 = V1_from_disp; n[f].q1 = Q1_from_disp;
        n[f].v2 = V2_from_disp; n[f].q2 = Q2_from_disp;
        n[f].pc = pc_from_disp; n[f].imm = imm_from_disp; n[f].rob = rob_id_from_disp;
        resolve(n[f].v1, n[f].q1);
        resolve(n[f].v2, n[f].q2);
      end
    end
    m = n;
  endtask

  task automatic cycle();
    chk("full_to_if", full_to_if, 32'(m_count() >= N - 2));
    @(posedge clk);
    #1;
    model_edge();
    chk("ena_to_alu", ena_to_alu, m_ena);
    chk("openum_to_alu", openum_to_alu, m_op);
    chk("V1_to_alu", V1_to_alu, m_v1);
    chk("V2_to_alu", V2_to_alu, m_v2);
    chk("pc_to_alu", pc_to_alu, m_pc);
    chk("imm_to_alu", imm_to_alu, m_imm);
    chk("rob_id_to_alu", rob_id_to_alu, m_rob);
  endtask

  task automatic idle();
    rdy = 1'b1; rollback = 1'b0; ena_from_disp = 1'b0;
    openum_from_disp = 0; V1_from_disp = 0; V2_from_disp = 0;
    Q1_from_disp = 0; Q2_from_disp = 0; pc_from_disp = 0; imm_from_disp = 0;
    rob_id_from_disp = 0;
    arith_cdb_valid = 1'b0; arith_cdb_rob_id = 0; arith_cdb_result = 0;
    ls_cdb_valid = 1'b0; ls_cdb_rob_id = 0; ls_cdb_result = 0;
  endtask

  task automatic set_disp(input openum_t op, input word_t v1, input word_t v2,
                          input rob_id_t q1, input rob_id_t q2, input rob_id_t rob);
    ena_from_disp = 1'b1; openum_from_disp = op;
    V1_from_disp = v1; V2_from_disp = v2; Q1_from_disp = q1; Q2_from_disp = q2;
    pc_from_disp = $urandom; imm_from_disp = $urandom; rob_id_from_disp = rob;
  endtask

  task automatic set_arith(input rob_id_t t, input word_t res);
    arith_cdb_valid = 1'b1; arith_cdb_rob_id = t; arith_cdb_result = res;
  endtask

  task automatic set_ls(input rob_id_t t, input word_t res);
    ls_cdb_valid = 1'b1; ls_cdb_rob_id = t; ls_cdb_result = res;
  endtask

  initial begin
    rob_id_t ta, tl;
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("rst_ena", ena_to_alu, 0);
    chk("rst_openum", openum_to_alu, OPENUM_NOP);
    chk("rst_v1", V1_to_alu, 0);
    chk("rst_pc", pc_to_alu, 0);
    chk("rst_rob", rob_id_to_alu, 0);
    chk("rst_full", full_to_if, 0);
    rst = 1'b0;

    // Ready operands: one cycle in the station, then issue.
    set_disp(6'd1, 32'd5, 32'd7, 0, 0, 5'd3);
    cycle();
    chk("t1_no_same_edge", ena_to_alu, 0);
    idle(); cycle();
    chk("t1_ena", ena_to_alu, 1);
    chk("t1_v1", V1_to_alu, 5);
    chk("t1_v2", V2_to_alu, 7);
    chk("t1_rob", rob_id_to_alu, 3);
    cycle();
    chk("t1_pulse", ena_to_alu, 0);

    // Wakeup by the arith CDB a few cycles after dispatch.
    set_disp(6'd2, 32'h0, 32'd1, 5'd4, 0, 5'd5);
    cycle();
    idle(); cycle(); cycle();
    set_arith(5'd4, 32'h10); cycle();
    idle(); cycle();
    chk("t2_ena", ena_to_alu, 1);
    chk("t2_v1", V1_to_alu, 32'h10);
    cycle();

    // Same-cycle forwarding from the LS CDB at insertion.
    set_disp(6'd3, 32'd9, 32'h0, 0, 5'd6, 5'd7);
    set_ls(5'd6, 32'hAB);
    cycle();
    idle(); cycle();
    chk("t3_ena", ena_to_alu, 1);
    chk("t3_v2", V2_to_alu, 32'hAB);
    cycle();

    // Fill 14 blocked entries, then release them all at once.
    for (int i = 0; i < 14; i++) begin
      set_disp(6'd4, 32'h0, 32'(i), 5'd9, 0, 5'(10 + i));
      cycle();
    end
    chk("t4_full", full_to_if, 1);
    idle(); set_arith(5'd9, 32'h99); cycle();
    idle();
    for (int i = 0; i < 14; i++) begin
      cycle();
      chk("t4_order", rob_id_to_alu, 32'(10 + i));
    end
    chk("t4_not_full", full_to_if, 0);
    cycle();

    // Rollback discards pending entries; a later broadcast wakes nothing.
    for (int i = 0; i < 5; i++) begin
      set_disp(6'd5, 32'h0, 32'h1, 5'd9, 0, 5'(1 + i));
      cycle();
    end
    idle(); rollback = 1'b1; set_arith(5'd9, 32'h1); cycle();
    idle(); set_arith(5'd9, 32'h2); cycle();
    idle();
    for (int i = 0; i < 3; i++) cycle();
    chk("t5_no_issue", ena_to_alu, 0);
    chk("t5_not_full", full_to_if, 0);

    // rdy low freezes everything: no issue, broadcast missed.
    set_disp(6'd6, 32'h0, 32'h2, 5'd12, 0, 5'd1); cycle();
    set_disp(6'd7, 32'h3, 32'h4, 0, 0, 5'd2); cycle();
    idle(); rdy = 1'b0; set_arith(5'd12, 32'h55);
    for (int i = 0; i < 3; i++) cycle();
    chk("t6_frozen", ena_to_alu, 0);
    idle(); cycle();
    chk("t6_ready_issue", rob_id_to_alu, 2);
    cycle(); cycle(); cycle();
    chk("t6_cdb_missed", ena_to_alu, 0);
    set_arith(5'd12, 32'h66); cycle();
    idle(); cycle();
    chk("t6_late_wake", V1_to_alu, 32'h66);

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      idle();
      rdy = ($urandom_range(0, 9) != 0);
      rollback = ($urandom_range(0, 49) == 0);
      if (m_count() < N - 2 && $urandom_range(0, 1) == 1) begin
        set_disp(openum_t'($urandom_range(1, 63)), $urandom, $urandom,
                 $urandom_range(0, 1) ? rob_id_t'(0) : rob_id_t'($urandom_range(1, 7)),
                 $urandom_range(0, 1) ? rob_id_t'(0) : rob_id_t'($urandom_range(1, 7)),
                 rob_id_t'($urandom_range(0, 31)));
      end
      ta = rob_id_t'($urandom_range(1, 7));
      tl = rob_id_t'($urandom_range(1, 7));
      if (tl == ta) tl = rob_id_t'((ta % 7) + 1);
      if ($urandom_range(0, 4) < 2) set_arith(ta, $urandom);
      if ($urandom_range(0, 4) < 2) set_ls(tl, $urandom);
      cycle();
    end
    idle();
    for (int i = 0; i < 20; i++) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
